// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Control-side partner of the ALU. Fetches 32-bit instruction words, decodes
// them into the ALU input bundle, writes the ALU result back into a 16x32
// register file, tracks the F1/F2 compare flags and the program counter, and
// resolves conditional jumps through register 8.
//
// Instruction word:
//   [31:25] opcode  [24:21] rd  [20:17] rs1  [16:13] rs2  [15:0] imm
//   (imm overlaps rs2 and is only meaningful for the load opcodes 5/6)
//
// Ports:
//   clock        in   system clock, all state on the rising edge
//   reset_n      in   asynchronous active-low reset
//   run          in   start request, sampled only while idle
//   mem_req      out  instruction fetch request (high for the whole fetch)
//   mem_addr     out  fetch word address, always equal to pc
//   mem_ack      in   fetch complete, mem_rdata valid in this cycle
//   mem_rdata    in   instruction word
//   alu_instr    out  ALU opcode
//   alu_a        out  operand A (reg[rs1], or reg[rd] for loads)
//   alu_b        out  operand B (reg[rs2])
//   alu_reg8     out  contents of register 8
//   alu_value    out  16-bit immediate
//   alu_highlow  out  1 = load high half, 0 = load low half
//   alu_f1       out  flag F1
//   alu_f2       out  flag F2
//   alu_clock    out  one-cycle ALU evaluate strobe
//   alu_c        in   ALU result
//   alu_f3       in   ALU compare outcome
//   pc           out  current program counter
//   halted       out  sequencer stopped on the HALT opcode
// ---------------------------------------------------------------------------
module alu_sequencer #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              run,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [6:0]        alu_instr,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [31:0]       alu_reg8,
    output logic [15:0]       alu_value,
    output logic              alu_highlow,
    output logic              alu_f1,
    output logic              alu_f2,
    output logic              alu_clock,
    input  logic [31:0]       alu_c,
    input  logic              alu_f3,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    localparam logic [6:0] OP_LOAD_LO = 7'd5;
    localparam logic [6:0] OP_LOAD_HI = 7'd6;
    localparam logic [6:0] OP_WR_LAST = 7'd7;
    localparam logic [6:0] OP_CMP_LO  = 7'd8;
    localparam logic [6:0] OP_CMP_HI  = 7'd13;
    localparam logic [6:0] OP_JUMP    = 7'd14;
    localparam logic [6:0] OP_HALT    = 7'd127;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       ir_q;
    logic [31:0]       rf_q [16];
    logic              f1_q;
    logic              f2_q;
    logic              mem_req_q;
    logic              halted_q;

    // ALU result and compare outcome captured at the end of EXECUTE
    logic [31:0]       c_q;
    logic              f3_q;

    // Registered ALU input bundle; held from DECODE until the next DECODE
    logic [6:0]        alu_instr_q;
    logic [31:0]       alu_a_q;
    logic [31:0]       alu_b_q;
    logic [31:0]       alu_reg8_q;
    logic [15:0]       alu_value_q;
    logic              alu_highlow_q;
    logic              alu_f1_q;
    logic              alu_f2_q;
    logic              alu_clock_q;

    // -----------------------------------------------------------------------
    // Instruction field decode (from the instruction register)
    // -----------------------------------------------------------------------
    logic [6:0]        ir_op;
    logic [3:0]        ir_rd;
    logic [3:0]        ir_rs1;
    logic [3:0]        ir_rs2;
    logic [15:0]       ir_imm;
    logic              ir_is_load;
    logic              ir_writes_rd;
    logic              ir_is_cmp;
    logic              jump_taken;
    logic [31:0]       opa_d;
    logic [ADDR_W-1:0] pc_d;

    assign ir_op  = ir_q[31:25];
    assign ir_rd  = ir_q[24:21];
    assign ir_rs1 = ir_q[20:17];
    assign ir_rs2 = ir_q[16:13];
    assign ir_imm = ir_q[15:0];

    always_comb begin
        ir_is_load   = (ir_op == OP_LOAD_LO) || (ir_op == OP_LOAD_HI);
        ir_writes_rd = (ir_op <= OP_WR_LAST);
        ir_is_cmp    = (ir_op >= OP_CMP_LO) && (ir_op <= OP_CMP_HI);
        jump_taken   = (ir_op == OP_JUMP) && f1_q;

        // Loads merge the immediate into the existing destination value,
        // so the ALU needs reg[rd] on operand A rather than reg[rs1].
        opa_d = ir_is_load ? rf_q[ir_rd] : rf_q[ir_rs1];

        // The jump target comes from reg[8] as it stands in WRITEBACK; any
        // earlier write to reg[8] has already landed by then.
        if (jump_taken) begin
            pc_d = rf_q[8][ADDR_W-1:0];
        end else begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            ir_q          <= '0;
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
            f1_q          <= 1'b0;
            f2_q          <= 1'b0;
            mem_req_q     <= 1'b0;
            halted_q      <= 1'b0;
            c_q           <= '0;
            f3_q          <= 1'b0;
            alu_instr_q   <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_reg8_q    <= '0;
            alu_value_q   <= '0;
            alu_highlow_q <= 1'b0;
            alu_f1_q      <= 1'b0;
            alu_f2_q      <= 1'b0;
            alu_clock_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_q   <= S_FETCH;
                        mem_req_q <= 1'b1;
                    end
                end

                S_FETCH: begin
                    if (mem_ack) begin
                        ir_q      <= mem_rdata;
                        mem_req_q <= 1'b0;
                        state_q   <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    // reg[rs1] is read here, before any write of this
                    // instruction, so rd==rs1 sees the old value.
                    alu_instr_q   <= ir_op;
                    alu_a_q       <= opa_d;
                    alu_b_q       <= rf_q[ir_rs2];
                    alu_reg8_q    <= rf_q[8];
                    alu_value_q   <= ir_imm;
                    alu_highlow_q <= (ir_op == OP_LOAD_HI);
                    alu_f1_q      <= f1_q;
                    alu_f2_q      <= f2_q;
                    if (ir_op == OP_HALT) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q     <= S_EXECUTE;
                        alu_clock_q <= 1'b1;
                    end
                end

                S_EXECUTE: begin
                    alu_clock_q <= 1'b0;
                    c_q         <= alu_c;
                    f3_q        <= alu_f3;
                    state_q     <= S_WRITEBACK;
                end

                S_WRITEBACK: begin
                    if (ir_writes_rd) begin
                        rf_q[ir_rd] <= c_q;
                    end
                    if (ir_is_cmp) begin
                        f2_q <= f1_q;
                        f1_q <= f3_q;
                    end
                    pc_q      <= pc_d;
                    mem_req_q <= 1'b1;
                    state_q   <= S_FETCH;
                end

                S_HALT: begin
                    // Terminal until reset.
                    state_q <= S_HALT;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign mem_req     = mem_req_q;
    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign halted      = halted_q;
    assign alu_instr   = alu_instr_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_reg8    = alu_reg8_q;
    assign alu_value   = alu_value_q;
    assign alu_highlow = alu_highlow_q;
    assign alu_f1      = alu_f1_q;
    assign alu_f2      = alu_f2_q;
    assign alu_clock   = alu_clock_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for alu_sequencer: directed program with a small ALU model, expected
// ALU input bundles queued per instruction and compared on each ALU strobe.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

    logic        clock;
    logic        reset_n;
    logic        run;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [6:0]  alu_instr;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_reg8;
    logic [15:0] alu_value;
    logic        alu_highlow;
    logic        alu_f1;
    logic        alu_f2;
    logic        alu_clock;
    logic [31:0] alu_c;
    logic        alu_f3;
    logic [15:0] pc;
    logic        halted;

    logic        f3_drv;

    int checks = 0;
    int errors = 0;

    alu_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .run         (run),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .alu_instr   (alu_instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_reg8    (alu_reg8),
        .alu_value   (alu_value),
        .alu_highlow (alu_highlow),
        .alu_f1      (alu_f1),
        .alu_f2      (alu_f2),
        .alu_clock   (alu_clock),
        .alu_c       (alu_c),
        .alu_f3      (alu_f3),
        .pc          (pc),
        .halted      (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Simple ALU: add/sub/and/or/xor/pass-b, plus the two half-word loads.
    function automatic logic [31:0] alu_model(input logic [6:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [15:0] v,
                                              input logic hl);
        case (op)
            7'd0:    return a + b;
            7'd1:    return a - b;
            7'd2:    return a & b;
            7'd3:    return a | b;
            7'd4:    return a ^ b;
            7'd5,
            7'd6:    return hl ? {v, a[15:0]} : {a[31:16], v};
            7'd7:    return b;
            default: return 32'h0;
        endcase
    endfunction

    always_comb alu_c = alu_model(alu_instr, alu_a, alu_b, alu_value, alu_highlow);
    assign alu_f3 = f3_drv;

    typedef struct packed {
        logic [6:0]  instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] reg8;
        logic [15:0] value;
        logic        hl;
        logic        f1;
        logic        f2;
    } dec_t;

    dec_t exp_q[$];

    // Reference state of the sequencer
    logic [31:0] m_rf [16];
    logic        m_f1;
    logic        m_f2;
    logic [15:0] m_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = 32'h0;
        m_f1 = 1'b0;
        m_f2 = 1'b0;
        m_pc = 16'h0000;
    endtask

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, rd, rs1, rs2, 13'd0};
    endfunction

    function automatic logic [31:0] enc_ld(input logic [6:0] op, input logic [3:0] rd,
                                           input logic [15:0] imm);
        return {op, rd, 5'd0, imm};
    endfunction

    // Scoreboard consumer: each ALU strobe must present the queued bundle.
    always @(negedge clock) begin
        dec_t e;
        if (reset_n && alu_clock) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL sb_underflow: observed=empty expected=entry at pc=%h", pc);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("strobe pc=%h instr=%0d a=%h b=%h reg8=%h value=%h hl=%b f1=%b f2=%b",
                         pc, alu_instr, alu_a, alu_b, alu_reg8, alu_value, alu_highlow, alu_f1, alu_f2);
                chk("alu_instr", 32'(alu_instr), 32'(e.instr));
                chk("alu_a", alu_a, e.a);
                chk("alu_b", alu_b, e.b);
                chk("alu_reg8", alu_reg8, e.reg8);
                chk("alu_value", 32'(alu_value), 32'(e.value));
                chk("alu_highlow", 32'(alu_highlow), 32'(e.hl));
                chk("alu_f1", 32'(alu_f1), 32'(e.f1));
                chk("alu_f2", 32'(alu_f2), 32'(e.f2));
            end
        end
    end

    // Run one instruction starting at a falling edge inside FETCH. Fetch is
    // acked after 'delay' wait cycles; junk_ack drives mem_ack with a HALT
    // word while not fetching, which must be ignored.
    task automatic exec(input logic [31:0] instr, input int delay, input logic f3v,
                        input logic junk_ack, input string tag);
        dec_t        e;
        logic [6:0]  op;
        logic [3:0]  rd;
        logic [31:0] res;
        int          n;
        int          waits;
        bit          seen_exec;
        bit          done;

        op = instr[31:25];
        rd = instr[24:21];
        e.instr = op;
        e.a     = (op == 7'd5 || op == 7'd6) ? m_rf[rd] : m_rf[instr[20:17]];
        e.b     = m_rf[instr[16:13]];
        e.reg8  = m_rf[8];
        e.value = instr[15:0];
        e.hl    = (op == 7'd6);
        e.f1    = m_f1;
        e.f2    = m_f2;
        exp_q.push_back(e);
        f3_drv = f3v;

        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        n = 0;
        waits = 0;
        seen_exec = 0;
        done = 0;
        while (!done && n < 40) begin
            if (mem_req) begin
                chk({tag, "_addr"}, 32'(mem_addr), 32'(m_pc));
                if (waits >= delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = instr;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 32'hFFFF_FFFF;
                    waits++;
                end
            end else begin
                mem_ack   = junk_ack;
                mem_rdata = {7'd127, 25'd0};
            end
            @(negedge clock);
            n++;
            if (alu_clock) seen_exec = 1;
            else if (seen_exec && mem_req) done = 1;
        end
        mem_ack = 1'b0;
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL %s_timeout: observed=%0d cycles expected=completion", tag, n);
        end

        res = alu_model(e.instr, e.a, e.b, e.value, e.hl);
        if (op <= 7'd7) begin
            m_rf[rd] = res;
        end else if (op >= 7'd8 && op <= 7'd13) begin
            m_f2 = m_f1;
            m_f1 = f3v;
        end
        if (op == 7'd14 && m_f1) m_pc = m_rf[8][15:0];
        else m_pc = m_pc + 16'd1;

        $display("instr %s op=%0d delay=%0d cycles=%0d pc=%h", tag, op, delay, n, pc);
        chk({tag, "_pc"}, 32'(pc), 32'(m_pc));
        chk({tag, "_cycles"}, n, 4 + delay);
    endtask

    initial begin
        reset_n   = 1'b0;
        run       = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        f3_drv    = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_aluclk", 32'(alu_clock), 32'h0);
        chk("rst_alu_a", alu_a, 32'h0);
        run     = 1'b1;
        reset_n = 1'b1;
        @(negedge clock);
        chk("start_req", 32'(mem_req), 32'h1);
        chk("start_addr", 32'(mem_addr), 32'h0);
        run = 1'b0;

        // Loads, ADD, wait states
        exec(enc_ld(7'd5, 4'd1, 16'd5), 0, 1'b0, 1'b0, "ld_r1");
        exec(enc_ld(7'd5, 4'd2, 16'd7), 0, 1'b0, 1'b0, "ld_r2");
        exec(enc(7'd0, 4'd3, 4'd1, 4'd2), 0, 1'b0, 1'b0, "add_r3");
        exec(enc(7'd3, 4'd5, 4'd3, 4'd3), 3, 1'b0, 1'b0, "or_wait3");
        exec(enc_ld(7'd5, 4'd4, 16'h1234), 0, 1'b0, 1'b0, "ldlo_r4");
        exec(enc_ld(7'd6, 4'd4, 16'hABCD), 1, 1'b0, 1'b0, "ldhi_r4");
        exec(enc(7'd7, 4'd9, 4'd4, 4'd4), 0, 1'b0, 1'b0, "mov_r9");

        // Compare and jump, taken then not taken
        exec(enc_ld(7'd5, 4'd8, 16'h0040), 0, 1'b0, 1'b0, "ld_r8");
        exec(enc(7'd8, 4'd0, 4'd1, 4'd2), 0, 1'b1, 1'b1, "cmp_t");
        exec(enc(7'd14, 4'd0, 4'd0, 4'd0), 0, 1'b0, 1'b0, "jmp_taken");
        exec(enc(7'd9, 4'd0, 4'd1, 4'd2), 0, 1'b0, 1'b0, "cmp_f");
        exec(enc(7'd14, 4'd0, 4'd0, 4'd0), 2, 1'b0, 1'b0, "jmp_not");

        // reg8 written right before a jump, jump to the top of memory, wrap
        exec(enc(7'd10, 4'd0, 4'd1, 4'd2), 0, 1'b1, 1'b0, "cmp_t2");
        exec(enc_ld(7'd5, 4'd8, 16'hFFFF), 0, 1'b0, 1'b0, "ld_r8_top");
        exec(enc(7'd14, 4'd0, 4'd0, 4'd0), 0, 1'b0, 1'b0, "jmp_top");
        exec(enc(7'd20, 4'd3, 4'd1, 4'd1), 0, 1'b0, 1'b0, "nop_wrap");
        exec(enc(7'd0, 4'd1, 4'd1, 4'd3), 0, 1'b0, 1'b0, "add_rd_rs1");
        exec(enc(7'd7, 4'd0, 4'd1, 4'd1), 0, 1'b0, 1'b0, "mov_r1");

        // HALT
        mem_ack   = 1'b1;
        mem_rdata = {7'd127, 25'd0};
        @(negedge clock);
        mem_ack = 1'b0;
        @(negedge clock);
        $display("halt pc=%h halted=%b req=%b", pc, halted, mem_req);
        chk("halt_flag", 32'(halted), 32'h1);
        chk("halt_instr", 32'(alu_instr), 32'd127);
        for (int i = 0; i < 10; i++) begin
            run = 1'b1;
            @(negedge clock);
            chk("halt_req", 32'(mem_req), 32'h0);
            chk("halt_aluclk", 32'(alu_clock), 32'h0);
            chk("halt_pc", 32'(pc), 32'(m_pc));
        end
        run = 1'b0;

        // Reset back to idle, restart, then reset in the middle of a fetch
        reset_n = 1'b0;
        model_reset();
        @(negedge clock);
        chk("rst2_halted", 32'(halted), 32'h0);
        chk("rst2_pc", 32'(pc), 32'h0);
        run     = 1'b1;
        reset_n = 1'b1;
        @(negedge clock);
        chk("fetch2_req", 32'(mem_req), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        $display("async reset mid-fetch req=%b", mem_req);
        chk("async_req", 32'(mem_req), 32'h0);
        run = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("idle_req", 32'(mem_req), 32'h0);
        end
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        chk("restart_addr", 32'(mem_addr), 32'h0);
        exec(enc(7'd7, 4'd1, 4'd1, 4'd2), 0, 1'b0, 1'b0, "after_reset");

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Control-side counterpart of the ALU. It fetches 32-bit instruction words from memory and decodes them into the ALU's opcode, operand, immediate, high/low and flag inputs. It writes the ALU result back into a 16x32 register file, keeps the compare flags and the program counter, and resolves conditional jumps through register 8. It sits between instruction memory and the ALU and is the only driver of ALU inputs.

Parameters:
ADDR_W, 16, program counter / memory word-address width
RESET_PC, 0, PC value loaded on reset

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
run  in  1  start request, sampled only in IDLE
mem_req  out  1  instruction fetch request
mem_addr  out  ADDR_W  fetch word address (= pc)
mem_ack  in  1  fetch complete, mem_rdata valid this cycle
mem_rdata  in  32  instruction word
alu_instr  out  7  ALU opcode
alu_a  out  32  operand A
alu_b  out  32  operand B
alu_reg8  out  32  contents of register 8
alu_value  out  16  immediate
alu_highlow  out  1  1 = load high half, 0 = load low half
alu_f1  out  1  flag F1
alu_f2  out  1  flag F2
alu_clock  out  1  ALU evaluate strobe
alu_c  in  32  ALU result
alu_f3  in  1  ALU compare outcome
pc  out  ADDR_W  current program counter
halted  out  1  sequencer stopped on HALT opcode

Behaviour:
- Instruction format:
  - [31:25] opcode
  - [24:21] rd
  - [20:17] rs1
  - [16:13] rs2
  - [15:0] imm; overlaps rs2, used only by the load opcodes.
- Reset (async, reset_n=0):
  - State IDLE; pc=RESET_PC.
  - All registers, F1, F2 = 0.
  - mem_req, alu_clock, halted = 0.
  - alu_* outputs = 0.
- FSM: IDLE -> FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH; any state -> HALT.
  - IDLE: wait for run=1, then go to FETCH.
  - FETCH: mem_req=1, mem_addr=pc. On a clock edge with mem_ack=1, latch mem_rdata into the instruction register and go to DECODE. mem_ack outside FETCH is ignored.
  - DECODE: register all ALU outputs.
    - alu_instr = opcode; alu_a = reg[rs1]; alu_b = reg[rs2]; alu_reg8 = reg[8].
    - alu_value = imm; alu_highlow = (opcode==6); alu_f1 = F1; alu_f2 = F2.
    - Load opcodes 5/6: alu_a = reg[rd].
    - opcode 127 goes to HALT instead of EXECUTE.
  - EXECUTE: alu_clock=1, registered, exactly one cycle. alu_c and alu_f3 are sampled at the end of this cycle.
  - WRITEBACK: alu_clock=0, then update state by opcode:
    - 0-7: reg[rd] <= sampled alu_c.
    - 8-13: F2 <= F1, F1 <= sampled alu_f3; no register write.
    - 14: if F1=1, pc <= reg[8][ADDR_W-1:0]; no increment.
    - 15-126: NOP.
    - In all cases other than a taken jump: pc <= pc+1, wrapping modulo 2^ADDR_W.
  - HALT: halted=1, mem_req=0, alu_clock=0. Terminal until reset.
- ALU outputs hold their DECODE values through WRITEBACK and the next FETCH.
- Timing: minimum 4 cycles per instruction with mem_ack in the first FETCH cycle; each wait cycle adds 1.
- Write hazards:
  - rd==8 updates reg[8] before the next DECODE, so a jump immediately after sees the new value.
  - rd==rs1 reads the old value during DECODE.
- Reset asserted mid-fetch drops mem_req immediately, without waiting for a clock edge.

Test Plan:
- Reset: hold reset_n=0 -> pc=0, mem_req=0, halted=0. Release with run=1 -> mem_req=1, mem_addr=0 on the next cycle.
- ADD: reg1=5, reg2=7 preloaded via load ops; ADD rd=3 rs1=1 rs2=2; ALU model returns 12 -> reg3=12. pc advances by 1 every 4 cycles with zero-wait ack.
- Wait states: mem_ack delayed 3 cycles -> mem_req held, mem_addr stable, instruction takes 7 cycles.
- Load: opcode 5 imm=0x1234 rd=4, then opcode 6 imm=0xABCD rd=4 -> alu_highlow 0 then 1. alu_a equals reg4 each time.
- Compare and jump:
  - compare 8 with alu_f3=1 -> F1=1, F2=old F1.
  - reg8=0x0040, opcode 14 -> pc=0x0040.
  - Same sequence with F1=0 -> pc increments.
- Halt / wrap:
  - pc=0xFFFF with NOP -> pc=0x0000.
  - Opcode 127 -> halted=1, mem_req stays 0 forever. Reset returns the block to IDLE.
